// File: rtl/inst_loader_if.sv
// Byte-source / memory-write bundle for inst_loader.
// master : host side (drives start/bytes, observes loader status and writes)
// slave  : the loader itself
//   start_i     one-cycle pulse, begin/restart a load
//   byte_vld_i  source byte valid
//   byte_i      source byte
//   byte_rdy_o  loader can accept a byte
//   wr_en_o     memory write strobe
//   data_o      assembled little-endian word
//   addr_o      byte address of the word being written
//   cpu_hold_o  stall core / select addr_o onto the memory
//   done_o      load completed with good checksum (sticky)
//   err_o       load failed (sticky)
interface inst_loader_if #(
  parameter int unsigned CPU_WIDTH = 32
);
  logic                 start_i;
  logic                 byte_vld_i;
  logic [7:0]           byte_i;
  logic                 byte_rdy_o;
  logic                 wr_en_o;
  logic [CPU_WIDTH-1:0] data_o;
  logic [CPU_WIDTH-1:0] addr_o;
  logic                 cpu_hold_o;
  logic                 done_o;
  logic                 err_o;

  modport master (
    output start_i, byte_vld_i, byte_i,
    input  byte_rdy_o, wr_en_o, data_o, addr_o, cpu_hold_o, done_o, err_o
  );

  modport slave (
    input  start_i, byte_vld_i, byte_i,
    output byte_rdy_o, wr_en_o, data_o, addr_o, cpu_hold_o, done_o, err_o
  );
endinterface

// File: rtl/inst_loader.sv
// Framed byte-stream program loader for the instruction memory.
// Frame: len_lo, len_hi (word count), 4*len payload bytes (little-endian
// words), one checksum byte (sum of payload bytes mod 256).
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    inst_loader_if.slave (byte source in, memory write / status out)
module inst_loader #(
  parameter int unsigned CPU_WIDTH = 32,
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_loader_if.slave bus
);

  localparam logic [CPU_WIDTH-1:0] BASE      = CPU_WIDTH'(BASE_ADDR);
  localparam logic [31:0]          MAX_WORDS = 32'(MEM_DEPTH - BASE_ADDR / 4);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, DATA, CHK, DONE, ERR
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [15:0]          wcnt_q, wcnt_d;
  logic [15:0]          len_q, len_d;
  logic [23:0]          word_q, word_d;
  logic [7:0]           csum_q, csum_d;
  logic                 wr_en_q, wr_en_d;
  logic [CPU_WIDTH-1:0] data_q, data_d;
  logic [CPU_WIDTH-1:0] addr_q, addr_d;
  logic                 rdy_q, rdy_d;
  logic                 hold_q, hold_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic        accept;
  logic [15:0] len_rx;

  assign accept = bus.byte_vld_i && rdy_q;
  assign len_rx = {bus.byte_i, len_q[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      len_q   <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      wr_en_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= BASE;
      rdy_q   <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      len_q   <= len_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      wr_en_q <= wr_en_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      rdy_q   <= rdy_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    len_d   = len_q;
    word_d  = word_q;
    csum_d  = csum_q;
    wr_en_d = 1'b0;
    data_d  = data_q;
    addr_d  = addr_q;

    // addr_o holds the strobed word's address through the strobe cycle,
    // then steps to the next word.
    if (wr_en_q) begin
      addr_d = addr_q + CPU_WIDTH'(4);
    end

    if (bus.start_i) begin
      state_d = HDR0;
      idx_d   = '0;
      wcnt_d  = '0;
      len_d   = '0;
      csum_d  = '0;
      addr_d  = BASE;
    end else if (accept) begin
      unique case (state_q)
        HDR0: begin
          len_d[7:0] = bus.byte_i;
          state_d    = HDR1;
        end
        HDR1: begin
          len_d = len_rx;
          if (32'(len_rx) > MAX_WORDS) begin
            state_d = ERR;
          end else if (len_rx == 16'd0) begin
            state_d = CHK;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          csum_d = csum_q + bus.byte_i;
          idx_d  = idx_q + 2'd1;
          unique case (idx_q)
            2'd0: word_d[7:0]   = bus.byte_i;
            2'd1: word_d[15:8]  = bus.byte_i;
            2'd2: word_d[23:16] = bus.byte_i;
            2'd3: begin
              wr_en_d = 1'b1;
              data_d  = CPU_WIDTH'({bus.byte_i, word_q});
              wcnt_d  = wcnt_q + 16'd1;
              if (wcnt_q + 16'd1 == len_q) begin
                state_d = CHK;
              end
            end
            default: ;
          endcase
        end
        CHK: begin
          state_d = (bus.byte_i == csum_q) ? DONE : ERR;
        end
        default: ;
      endcase
    end

    // Status outputs are registered images of the next state.
    rdy_d  = state_d inside {HDR0, HDR1, DATA, CHK};
    hold_d = rdy_d || (state_d == ERR);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  assign bus.byte_rdy_o = rdy_q;
  assign bus.wr_en_o    = wr_en_q;
  assign bus.data_o     = data_q;
  assign bus.addr_o     = addr_q;
  assign bus.cpu_hold_o = hold_q;
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_loader_if #(.CPU_WIDTH(32)) bus ();

  inst_loader #(
    .CPU_WIDTH(32),
    .MEM_DEPTH(4096),
    .BASE_ADDR(0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          wr_c[$];
  logic [7:0]  stim[$];
  logic [31:0] m_a[$];
  logic [31:0] m_d[$];
  bit          m_done, m_err;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_en_o === 1'b1) begin
      wr_a.push_back(bus.addr_o);
      wr_d.push_back(bus.data_o);
      wr_c.push_back(cyc);
    end
  end

  typedef struct {
    int          off;
    int          n;
    int          nwr;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          done;
    bit          err;
    bit          hold;
  } vec_t;

  logic [7:0] pool[30] = '{
    8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h80, 8'h10, 8'h00, 8'h36,
    8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h80, 8'h10, 8'h00, 8'h37,
    8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h01,
    8'h01, 8'h10
  };

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.byte_vld_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.byte_i     = b;
    bus.byte_vld_i = 1'b1;
    while (bus.byte_rdy_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.byte_rdy_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte_rdy_o=%b after %0d cycles, expected 1", bus.byte_rdy_o, n);
    end
    @(negedge clk);
  endtask

  task automatic send_stim(input bit gaps);
    for (int i = 0; i < stim.size(); i++) begin
      if (gaps) idle($urandom_range(0, 3));
      send_byte(stim[i]);
    end
  endtask

  task automatic do_start();
    bus.byte_vld_i = 1'b0;
    bus.start_i    = 1'b1;
    @(negedge clk);
    bus.start_i    = 1'b0;
    chk("start_hold", 32'(bus.cpu_hold_o), 32'd1);
    chk("start_done", 32'(bus.done_o), 32'd0);
    chk("start_err", 32'(bus.err_o), 32'd0);
    chk("start_rdy", 32'(bus.byte_rdy_o), 32'd1);
    chk("start_addr", bus.addr_o, 32'h0);
    wr_a.delete(); wr_d.delete(); wr_c.delete();
  endtask

  // Frame-level interpretation of the stream: header, words, checksum.
  task automatic model();
    int unsigned len;
    logic [7:0]  sum;
    m_a.delete(); m_d.delete();
    m_done = 0; m_err = 0;
    len = {stim[1], stim[0]};
    if (len > 4096) begin
      m_err = 1;
      return;
    end
    sum = 8'h00;
    for (int unsigned w = 0; w < len; w++) begin
      logic [31:0] word = '0;
      for (int unsigned k = 0; k < 4; k++) begin
        word = word | (32'(stim[2 + 4*w + k]) << (8*k));
        sum  = sum + stim[2 + 4*w + k];
      end
      m_a.push_back(4 * w);
      m_d.push_back(word);
    end
    m_done = (stim[2 + 4*len] == sum);
    m_err  = !m_done;
  endtask

  task automatic build(input int nw, input bit corrupt);
    logic [7:0] sum = 8'h00;
    logic [7:0] b;
    stim.delete();
    stim.push_back(8'(nw));
    stim.push_back(8'(nw >> 8));
    for (int i = 0; i < 4*nw; i++) begin
      b = 8'($urandom);
      sum = sum + b;
      stim.push_back(b);
    end
    stim.push_back(corrupt ? sum + 8'h01 : sum);
  endtask

  task automatic check_vs_model(input string tag, input bit spacing);
    chk({tag, "_done_now"}, 32'(bus.done_o), 32'(m_done));
    chk({tag, "_err_now"}, 32'(bus.err_o), 32'(m_err));
    idle(3);
    chk({tag, "_nwr"}, 32'(wr_a.size()), 32'(m_a.size()));
    for (int i = 0; i < m_a.size() && i < wr_a.size(); i++) begin
      chk({tag, "_addr"}, wr_a[i], m_a[i]);
      chk({tag, "_data"}, wr_d[i], m_d[i]);
      if (spacing && i > 0) chk({tag, "_spacing"}, 32'(wr_c[i] - wr_c[i-1]), 32'd4);
    end
    chk({tag, "_hold"}, 32'(bus.cpu_hold_o), 32'(m_err));
    chk({tag, "_rdy_end"}, 32'(bus.byte_rdy_o), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sa[$];
    logic [31:0] sd[$];

    tbl[0] = '{off: 0,  n: 11, nwr: 2, w0: 32'h00000013, w1: 32'h00108093, done: 1, err: 0, hold: 0};
    tbl[1] = '{off: 11, n: 11, nwr: 2, w0: 32'h00000013, w1: 32'h00108093, done: 0, err: 1, hold: 1};
    tbl[2] = '{off: 22, n: 3,  nwr: 0, w0: 32'h0,        w1: 32'h0,        done: 1, err: 0, hold: 0};
    tbl[3] = '{off: 25, n: 3,  nwr: 0, w0: 32'h0,        w1: 32'h0,        done: 0, err: 1, hold: 1};
    tbl[4] = '{off: 28, n: 2,  nwr: 0, w0: 32'h0,        w1: 32'h0,        done: 0, err: 1, hold: 1};

    bus.start_i = 1'b0;
    bus.byte_vld_i = 1'b0;
    bus.byte_i = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_rdy", 32'(bus.byte_rdy_o), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en_o), 32'd0);
    chk("rst_data", bus.data_o, 32'h0);
    chk("rst_addr", bus.addr_o, 32'h0);
    chk("rst_hold", 32'(bus.cpu_hold_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    bus.byte_i = 8'hAA;
    bus.byte_vld_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_rdy", 32'(bus.byte_rdy_o), 32'd0);
    chk("idle_nwr", 32'(wr_a.size()), 32'd0);
    bus.byte_vld_i = 1'b0;

    for (int t = 0; t < 5; t++) begin
      stim.delete();
      for (int i = 0; i < tbl[t].n; i++) stim.push_back(pool[tbl[t].off + i]);
      do_start();
      send_stim(1'b0);
      chk($sformatf("tbl%0d_done_now", t), 32'(bus.done_o), 32'(tbl[t].done));
      chk($sformatf("tbl%0d_err_now", t), 32'(bus.err_o), 32'(tbl[t].err));
      idle(3);
      chk($sformatf("tbl%0d_nwr", t), 32'(wr_a.size()), 32'(tbl[t].nwr));
      if (tbl[t].nwr > 0 && wr_a.size() > 0) begin
        chk($sformatf("tbl%0d_a0", t), wr_a[0], 32'h0);
        chk($sformatf("tbl%0d_d0", t), wr_d[0], tbl[t].w0);
      end
      if (tbl[t].nwr > 1 && wr_a.size() > 1) begin
        chk($sformatf("tbl%0d_a1", t), wr_a[1], 32'h4);
        chk($sformatf("tbl%0d_d1", t), wr_d[1], tbl[t].w1);
      end
      chk($sformatf("tbl%0d_hold", t), 32'(bus.cpu_hold_o), 32'(tbl[t].hold));
      chk($sformatf("tbl%0d_done", t), 32'(bus.done_o), 32'(tbl[t].done));
      chk($sformatf("tbl%0d_err", t), 32'(bus.err_o), 32'(tbl[t].err));
    end

    // 8 words continuous, then the same stream with random valid gaps.
    build(8, 1'b0);
    model();
    do_start();
    send_stim(1'b0);
    check_vs_model("w8_cont", 1'b1);
    sa = wr_a;
    sd = wr_d;
    do_start();
    send_stim(1'b1);
    check_vs_model("w8_gap", 1'b0);
    chk("w8_same_nwr", 32'(wr_a.size()), 32'(sa.size()));
    for (int i = 0; i < sa.size() && i < wr_a.size(); i++) begin
      chk("w8_same_addr", wr_a[i], sa[i]);
      chk("w8_same_data", wr_d[i], sd[i]);
    end

    for (int r = 0; r < 6; r++) begin
      build($urandom_range(1, 5), ($urandom_range(0, 2) == 0));
      model();
      do_start();
      send_stim(r[0]);
      check_vs_model($sformatf("rnd%0d", r), 1'b0);
    end

    // Abort after the 6th payload byte, then a fresh one-word load.
    stim = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_start();
    send_stim(1'b0);
    idle(2);
    chk("abort_nwr", 32'(wr_a.size()), 32'd1);
    if (wr_a.size() > 0) begin
      chk("abort_a0", wr_a[0], 32'h0);
      chk("abort_d0", wr_d[0], 32'h44332211);
    end
    build(1, 1'b0);
    model();
    do_start();
    send_stim(1'b0);
    check_vs_model("after_abort", 1'b0);

    // Asynchronous reset in the middle of a word.
    stim = '{8'h01, 8'h00, 8'hAB, 8'hCD};
    do_start();
    send_stim(1'b0);
    bus.byte_i = 8'hEF;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_rdy", 32'(bus.byte_rdy_o), 32'd0);
    chk("mrst_wr_en", 32'(bus.wr_en_o), 32'd0);
    chk("mrst_addr", bus.addr_o, 32'h0);
    chk("mrst_hold", 32'(bus.cpu_hold_o), 32'd0);
    chk("mrst_done", 32'(bus.done_o), 32'd0);
    chk("mrst_err", 32'(bus.err_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    idle(2);
    chk("mrst_nwr", 32'(wr_a.size()), 32'd0);
    chk("mrst_idle_rdy", 32'(bus.byte_rdy_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
